risc_seq_controller: RTL and testbench

Sequencing controller for the RISC CPU: the next generation of the combinational phase decoder. It owns its own 3-bit phase counter, stalls on a memory-ready handshake, and latches halt and illegal-opcode states until an external resume. It sits between the instruction register/accumulator-zero flag and the datapath/memory control strobes, replacing the external phase counter plus decoder pair.

---
 rtl/risc_pkg.sv | 33 +++
 rtl/risc_phase_ctr.sv | 23 ++
 rtl/risc_seq_controller.sv | 150 +++++++++++++++
 tb/tb_risc_seq_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared RISC CPU encodings: opcodes, phase numbering and controller states.
package risc_pkg;

    localparam int unsigned OP_BASE_W = 3;
    localparam int unsigned PHASE_W   = 3;

    typedef logic [PHASE_W-1:0] phase_t;

    localparam logic [OP_BASE_W-1:0] OP_HLT = 3'd0;
    localparam logic [OP_BASE_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OP_BASE_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_BASE_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_BASE_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_BASE_W-1:0] OP_LDA = 3'd5;
    localparam logic [OP_BASE_W-1:0] OP_STO = 3'd6;
    localparam logic [OP_BASE_W-1:0] OP_JMP = 3'd7;

    localparam phase_t PH_ADDR   = 3'd0;
    localparam phase_t PH_FETCH  = 3'd1;
    localparam phase_t PH_IR_LO  = 3'd2;
    localparam phase_t PH_IR_HI  = 3'd3;
    localparam phase_t PH_DECODE = 3'd4;
    localparam phase_t PH_OP_RD  = 3'd5;
    localparam phase_t PH_EXEC   = 3'd6;
    localparam phase_t PH_WB     = 3'd7;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_TRAP
    } state_t;

endpackage

// File: rtl/risc_phase_ctr.sv
// 3-bit wrapping phase counter with hold and synchronous clear-to-zero.
module risc_phase_ctr
    import risc_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   load,
    output phase_t phase
);

    // load wins over hold so a resume always lands on phase 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= PH_ADDR;
        end else if (load) begin
            phase <= PH_ADDR;
        end else if (!hold) begin
            phase <= phase + PHASE_W'(1);
        end
    end

endmodule

// File: rtl/risc_seq_controller.sv
// RISC sequencing controller: run/halt/trap state, opcode decode and Moore strobe decode.
module risc_seq_controller
    import risc_pkg::*;
#(
    parameter int unsigned OPCODE_W = 3,
    parameter bit          WAIT_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_rdy,
    input  logic                go,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                halt,
    output logic                ld_pc,
    output logic                data_e,
    output logic                ld_ac,
    output logic                wr,
    output logic                illegal,
    output logic [2:0]          phase
);

    // widened copy so codes >= 8 never alias onto the base opcodes
    localparam int unsigned EXT_W = OPCODE_W + 4;

    state_t           state;
    state_t           next_state;
    phase_t           ph;
    logic [EXT_W-1:0] op_x;
    logic             dec_h, dec_a, dec_z, dec_j, dec_s, dec_i;
    logic             rdy;
    logic             ctr_hold;
    logic             ctr_load;

    assign op_x  = EXT_W'(opcode);
    assign dec_h = (op_x == EXT_W'(OP_HLT));
    assign dec_a = (op_x == EXT_W'(OP_ADD)) || (op_x == EXT_W'(OP_AND)) ||
                   (op_x == EXT_W'(OP_XOR)) || (op_x == EXT_W'(OP_LDA));
    assign dec_z = (op_x == EXT_W'(OP_SKZ)) && zero;
    assign dec_j = (op_x == EXT_W'(OP_JMP));
    assign dec_s = (op_x == EXT_W'(OP_STO));
    assign dec_i = (op_x >= EXT_W'(8));
    assign rdy   = WAIT_EN ? mem_rdy : 1'b1;

    risc_phase_ctr u_phase_ctr (
        .clk   (clk),
        .rst   (rst),
        .hold  (ctr_hold),
        .load  (ctr_load),
        .phase (ph)
    );

    assign phase = ph;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // next state, counter control and strobes
    always_comb begin
        next_state = state;
        ctr_hold   = 1'b0;
        ctr_load   = 1'b0;
        sel        = 1'b0;
        rd         = 1'b0;
        ld_ir      = 1'b0;
        inc_pc     = 1'b0;
        halt       = 1'b0;
        ld_pc      = 1'b0;
        data_e     = 1'b0;
        ld_ac      = 1'b0;
        wr         = 1'b0;
        illegal    = 1'b0;

        case (state)
            ST_RUN: begin
                case (ph)
                    PH_ADDR: begin
                        sel = 1'b1;
                    end
                    PH_FETCH: begin
                        sel = 1'b1;
                        rd  = 1'b1;
                    end
                    PH_IR_LO: begin
                        sel   = 1'b1;
                        rd    = 1'b1;
                        ld_ir = 1'b1;
                    end
                    PH_IR_HI: begin
                        sel      = 1'b1;
                        rd       = 1'b1;
                        ld_ir    = 1'b1;
                        ctr_hold = !rdy;
                    end
                    PH_DECODE: begin
                        inc_pc = 1'b1;
                        halt   = dec_h;
                        if (dec_h) begin
                            next_state = ST_HALTED;
                            ctr_hold   = 1'b1;
                        end else if (dec_i) begin
                            next_state = ST_TRAP;
                            ctr_hold   = 1'b1;
                        end
                    end
                    PH_OP_RD: begin
                        rd = dec_a;
                    end
                    PH_EXEC: begin
                        rd     = dec_a;
                        inc_pc = dec_z;
                        ld_pc  = dec_j;
                        data_e = dec_s;
                    end
                    default: begin
                        rd       = dec_a;
                        ld_pc    = dec_j;
                        data_e   = dec_s;
                        ld_ac    = dec_a;
                        wr       = dec_s;
                        ctr_hold = !rdy && (dec_a || dec_s);
                    end
                endcase
            end
            ST_HALTED, ST_TRAP: begin
                halt     = 1'b1;
                illegal  = (state == ST_TRAP);
                ctr_hold = 1'b1;
                if (go) begin
                    next_state = ST_RUN;
                    ctr_load   = 1'b1;
                end
            end
            default: begin
                next_state = ST_RUN;
                ctr_load   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_risc_seq_controller.sv
// Self-checking bench for risc_seq_controller: per-cycle expected strobes via a scoreboard queue.
module tb_risc_seq_controller;

    localparam logic [12:0] HALT_V = 13'h0104;
    localparam logic [12:0] TRAP_V = 13'h010C;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic [3:0] opcode4;
    logic       zero;
    logic       mem_rdy;
    logic       go;

    logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, illegal;
    logic [2:0] phase;
    logic sel4, rd4, ld_ir4, inc_pc4, halt4, ld_pc4, data_e4, ld_ac4, wr4, illegal4;
    logic [2:0] phase4;

    logic [12:0] obs, obs4;
    logic [12:0] sb [$];
    int n_checks;
    int n_fail;

    risc_seq_controller #(.OPCODE_W(3), .WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy), .go(go),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .halt(halt), .ld_pc(ld_pc),
        .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .illegal(illegal), .phase(phase)
    );

    risc_seq_controller #(.OPCODE_W(4), .WAIT_EN(1'b1)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode4), .zero(zero), .mem_rdy(mem_rdy), .go(go),
        .sel(sel4), .rd(rd4), .ld_ir(ld_ir4), .inc_pc(inc_pc4), .halt(halt4), .ld_pc(ld_pc4),
        .data_e(data_e4), .ld_ac(ld_ac4), .wr(wr4), .illegal(illegal4), .phase(phase4)
    );

    assign obs  = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, illegal, phase};
    assign obs4 = {sel4, rd4, ld_ir4, inc_pc4, halt4, ld_pc4, data_e4, ld_ac4, wr4, illegal4, phase4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe table of a RUN phase for a given opcode
    function automatic logic [12:0] ph_exp(input logic [2:0] p, input int op, input logic z);
        logic a, s, j, h, zz;
        logic [12:0] v;
        a  = (op >= 2) && (op <= 5);
        s  = (op == 6);
        j  = (op == 7);
        h  = (op == 0);
        zz = (op == 1) && z;
        v  = '0;
        case (p)
            3'd0: v[12] = 1'b1;
            3'd1: begin v[12] = 1'b1; v[11] = 1'b1; end
            3'd2, 3'd3: begin v[12] = 1'b1; v[11] = 1'b1; v[10] = 1'b1; end
            3'd4: begin v[9] = 1'b1; v[8] = h; end
            3'd5: v[11] = a;
            3'd6: begin v[11] = a; v[9] = zz; v[7] = j; v[6] = s; end
            default: begin v[11] = a; v[7] = j; v[6] = s; v[5] = a; v[4] = s; end
        endcase
        v[2:0] = p;
        return v;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        go  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] e, got;
        rst = 1'b1;
        sb.push_back(13'h1000);
        sb.push_back(13'h1000);
        @(negedge clk);
        got = obs; e = sb.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset: got %h exp %h", got, e); end
        got = obs4; e = sb.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL reset4: got %h exp %h", got, e); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_lda();
        logic [12:0] e, got;
        apply_reset();
        opcode = 3'd5; mem_rdy = 1'b1; zero = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(ph_exp(3'(i % 8), 5, 1'b0));
            @(negedge clk);
            got = obs; e = sb.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL lda cyc %0d: got %h exp %h", i, got, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_sto_stall();
        logic [12:0] e, got;
        int   ph  [12];
        logic rdy [12];
        ph  = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 0};
        rdy = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
        apply_reset();
        opcode = 3'd6; zero = 1'b0;
        for (int i = 0; i < 12; i++) begin
            mem_rdy = rdy[i];
            sb.push_back(ph_exp(3'(ph[i]), 6, 1'b0));
            @(negedge clk);
            got = obs; e = sb.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL sto cyc %0d: got %h exp %h", i, got, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_skz();
        logic [12:0] e, got;
        int   ph  [11];
        logic rdy [11];
        // Ph3 stalls twice; mem_rdy low at Ph5 and at Ph7 (no A/S) is ignored
        ph  = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7, 0};
        rdy = '{1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1};
        apply_reset();
        opcode = 3'd1; zero = 1'b1;
        for (int i = 0; i < 11; i++) begin
            mem_rdy = rdy[i];
            sb.push_back(ph_exp(3'(ph[i]), 1, 1'b1));
            @(negedge clk);
            got = obs; e = sb.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL skz1 cyc %0d: got %h exp %h", i, got, e); end
            @(posedge clk);
            #1;
        end
        apply_reset();
        zero = 1'b0; mem_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(ph_exp(3'(i % 8), 1, 1'b0));
            @(negedge clk);
            got = obs; e = sb.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL skz0 cyc %0d: got %h exp %h", i, got, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_halt_resume();
        logic [12:0] e, got;
        apply_reset();
        opcode = 3'd0; zero = 1'b0; mem_rdy = 1'b1;
        for (int i = 0; i < 28; i++) begin
            go = (i == 2) || (i == 25);
            if (i < 5)       sb.push_back(ph_exp(3'(i), 0, 1'b0));
            else if (i < 26) sb.push_back(HALT_V);
            else             sb.push_back(ph_exp(3'(i - 26), 0, 1'b0));
            @(negedge clk);
            got = obs; e = sb.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL halt cyc %0d: got %h exp %h", i, got, e); end
            @(posedge clk);
            #1;
        end
        go = 1'b0;
    endtask

    task automatic test_trap();
        logic [12:0] e, got;
        apply_reset();
        opcode = 3'd5; opcode4 = 4'd9; zero = 1'b0;
        for (int i = 0; i < 10; i++) begin
            go      = (i == 7);
            mem_rdy = (i != 4);
            if (i < 5)      sb.push_back(ph_exp(3'(i), 9, 1'b0));
            else if (i < 8) sb.push_back(TRAP_V);
            else            sb.push_back(ph_exp(3'(i - 8), 9, 1'b0));
            @(negedge clk);
            got = obs4; e = sb.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL trap cyc %0d: got %h exp %h", i, got, e); end
            @(posedge clk);
            #1;
        end
        go = 1'b0; mem_rdy = 1'b1; opcode4 = 4'd5;
    endtask

    task automatic test_rst_mid();
        logic [12:0] e, got;
        apply_reset();
        opcode = 3'd7; zero = 1'b0; mem_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(ph_exp(3'(i), 7, 1'b0));
            @(negedge clk);
            got = obs; e = sb.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL jmp cyc %0d: got %h exp %h", i, got, e); end
            if (i < 6) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        rst = 1'b1;
        sb.push_back(13'h1000);
        #1;
        got = obs; e = sb.pop_front(); n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL async_rst: got %h exp %h", got, e); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ph_exp(3'(i), 7, 1'b0));
            @(negedge clk);
            got = obs; e = sb.pop_front(); n_checks++;
            if (got !== e) begin n_fail++; $display("FAIL post_rst cyc %0d: got %h exp %h", i, got, e); end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        opcode   = 3'd5;
        opcode4  = 4'd5;
        zero     = 1'b0;
        mem_rdy  = 1'b1;
        go       = 1'b0;
        test_reset();
        test_lda();
        test_sto_stall();
        test_skz();
        test_halt_resume();
        test_trap();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
